// File: rtl/ret_addr_stack_pkg.sv
// Shared MIPS pipeline constants for the return-address stack.
// The overflow policy is selected by the RAS_OVERFLOW_WRAP_EN macro in ret_addr_stack.
package mips_defs;

    localparam int          RAS_DEPTH_DEFAULT = 8;
    localparam logic [31:0] LINK_OFFSET       = 32'd8;
    localparam logic [4:0]  REG_RA            = 5'd31;

    // Return target of a call: skip the call and its delay slot.
    function automatic logic [31:0] link_addr(input logic [31:0] call_pc);
        return call_pc + LINK_OFFSET;
    endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// ID/EX-side signal bundle of the return-address stack.
// The pipeline owns the master modport; the stack itself uses the slave modport.
interface ret_addr_stack_if
    import mips_defs::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
);

    logic          Stall;
    logic          Push;
    logic [31:0]   Push_pc;
    logic          Pop;
    logic [31:0]   Pred_pc;
    logic          Pred_valid;
    logic          Resolve;
    logic [31:0]   Resolve_pc;
    logic [31:0]   Resolve_pred;
    logic          Mispredict;
    logic [AW:0]   Count;

    modport master (
        output Stall, Push, Push_pc, Pop, Resolve, Resolve_pc, Resolve_pred,
        input  Pred_pc, Pred_valid, Mispredict, Count
    );

    modport slave (
        input  Stall, Push, Push_pc, Pop, Resolve, Resolve_pc, Resolve_pred,
        output Pred_pc, Pred_valid, Mispredict, Count
    );

endinterface

// File: rtl/ret_addr_stack_mem.sv
// Storage array of the return-address stack: one write port, one
// asynchronous read port, and an asynchronous clear of every entry.
module ras_mem
    import mips_defs::*;
#(
    parameter int DEPTH  = RAS_DEPTH_DEFAULT,
    parameter int AW     = $clog2(DEPTH),
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack predicting `jr $31` targets in ID, with EX-side mispredict flag.
// RAS_OVERFLOW_WRAP_EN: when defined, a push on a full stack overwrites the oldest entry.
module ret_addr_stack
    import mips_defs::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    ret_addr_stack_if.slave   bus
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ret_addr_stack: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0] top_q, top_d;
    logic [AW:0]   count_q, count_d;
    logic          mispredict_p1;

    logic          empty, full;
    logic          push_en, pop_en;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   top_entry;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign mem_wdata = link_addr(bus.Push_pc);

    // Pointer / count next-state; a pop on an empty stack is simply ignored.
    always_comb begin
        push_en   = bus.Push & ~bus.Stall;
        pop_en    = bus.Pop & ~bus.Stall & ~empty;
        top_d     = top_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = top_q;

        if (push_en && pop_en) begin
            // Call that also returns: retarget the current top in place.
            mem_we = 1'b1;
        end else if (push_en) begin
            if (!full) begin
                top_d     = top_q + PTR_ONE;
                count_d   = count_q + CNT_ONE;
                mem_we    = 1'b1;
                mem_waddr = top_q + PTR_ONE;
            end
`ifdef RAS_OVERFLOW_WRAP_EN
            else begin
                top_d     = top_q + PTR_ONE;
                mem_we    = 1'b1;
                mem_waddr = top_q + PTR_ONE;
            end
`endif
        end else if (pop_en) begin
            top_d   = top_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    ras_mem #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (32)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr   (top_q),
        .rdata   (top_entry)
    );

    // EX stage: compare the carried prediction against the real $31.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispredict_p1 <= 1'b0;
        end else begin
            mispredict_p1 <= bus.Resolve && (bus.Resolve_pc != bus.Resolve_pred);
        end
    end

    // Stale entries survive pops, so the prediction is masked when empty.
    assign bus.Pred_pc    = empty ? 32'h0 : top_entry;
    assign bus.Pred_valid = ~empty;
    assign bus.Mispredict = mispredict_p1;
    assign bus.Count      = count_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Scoreboard bench for ret_addr_stack: stimulus queues expected predictions and
// mispredict values, a negedge monitor pops and compares them.
module tb_ret_addr_stack;
    import mips_defs::*;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        int          cnt;
    } pred_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    pred_t pred_q[$];
    logic  mp_q[$];
    logic  res_pending;

    ret_addr_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    ret_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares Mispredict every cycle and the prediction on each live Pop.
    always @(negedge clk) begin
        pred_t e;
        logic  exp_mp;
        if (!reset_n) begin
            mp_q.delete();
            res_pending = 1'b0;
        end else begin
            exp_mp = 1'b0;
            if (res_pending) begin
                if (mp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL mp_queue: got empty queue, required an entry");
                end else begin
                    exp_mp = mp_q.pop_front();
                end
            end
            check32("mispredict", {31'b0, bus.Mispredict}, {31'b0, exp_mp});
            res_pending = bus.Resolve;
            if (bus.Pop && !bus.Stall) begin
                if (pred_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pred_queue: got unexpected pop, required none");
                end else begin
                    e = pred_q.pop_front();
                    check32("pop_pred_valid", {31'b0, bus.Pred_valid}, {31'b0, e.pv});
                    check32("pop_pred_pc", bus.Pred_pc, e.pc);
                    check32("pop_count", 32'(bus.Count), 32'(e.cnt));
                end
            end
        end
    end

    task automatic step(input logic push, input logic [31:0] ppc, input logic pop, input logic stall);
        bus.Push    = push;
        bus.Push_pc = ppc;
        bus.Pop     = pop;
        bus.Stall   = stall;
        @(posedge clk);
        #1;
        bus.Push    = 1'b0;
        bus.Pop     = 1'b0;
        bus.Stall   = 1'b0;
        bus.Resolve = 1'b0;
    endtask

    task automatic pop_exp(input logic pv, input logic [31:0] pc, input int cnt);
        pred_t e;
        e.pv = pv; e.pc = pc; e.cnt = cnt;
        pred_q.push_back(e);
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] rpc, input logic [31:0] rpred, input logic exp_mp);
        bus.Resolve      = 1'b1;
        bus.Resolve_pc   = rpc;
        bus.Resolve_pred = rpred;
        mp_q.push_back(exp_mp);
        step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        res_pending      = 1'b0;
        reset_n          = 1'b0;
        bus.Stall        = 1'b0;
        bus.Push         = 1'b0;
        bus.Push_pc      = 32'h0;
        bus.Pop          = 1'b0;
        bus.Resolve      = 1'b0;
        bus.Resolve_pc   = 32'h0;
        bus.Resolve_pred = 32'h0;
        #12;
        check32("reset_count", 32'(bus.Count), 32'd0);
        check32("reset_pred_valid", {31'b0, bus.Pred_valid}, 32'd0);
        check32("reset_pred_pc", bus.Pred_pc, 32'h0);
        check32("reset_mispredict", {31'b0, bus.Mispredict}, 32'd0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        // Pop on an empty stack
        pop_exp(1'b0, 32'h0, 0);
        check32("empty_pop_count", 32'(bus.Count), 32'd0);

        // Single push then pop
        step(1'b1, 32'h0040_0010, 1'b0, 1'b0);
        check32("single_push_count", 32'(bus.Count), 32'd1);
        pop_exp(1'b1, 32'h0040_0018, 1);
        check32("single_pop_count", 32'(bus.Count), 32'd0);

        // Three pushes, three pops
        step(1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b0);
        pop_exp(1'b1, 32'h308, 3);
        pop_exp(1'b1, 32'h208, 2);
        pop_exp(1'b1, 32'h108, 1);
        check32("three_empty_valid", {31'b0, bus.Pred_valid}, 32'd0);

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) step(1'b1, 32'(i * 16), 1'b0, 1'b0);
        check32("full_count", 32'(bus.Count), 32'd8);
        for (int k = 0; k < 8; k++) begin
`ifdef RAS_OVERFLOW_WRAP_EN
            pop_exp(1'b1, 32'(32'h88 - k * 16), 8 - k);
`else
            pop_exp(1'b1, 32'(32'h78 - k * 16), 8 - k);
`endif
        end
        check32("overflow_end_count", 32'(bus.Count), 32'd0);
        check32("overflow_end_pc", bus.Pred_pc, 32'h0);

        // Push+Pop on empty behaves as a push
        pred_q.push_back('{pv: 1'b0, pc: 32'h0, cnt: 0});
        step(1'b1, 32'h600, 1'b1, 1'b0);
        check32("pp_empty_count", 32'(bus.Count), 32'd1);
        check32("pp_empty_pc", bus.Pred_pc, 32'h608);
        pop_exp(1'b1, 32'h608, 1);

        // Push+Pop with two entries replaces the top
        step(1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'h200, 1'b0, 1'b0);
        pred_q.push_back('{pv: 1'b1, pc: 32'h208, cnt: 2});
        step(1'b1, 32'h400, 1'b1, 1'b0);
        check32("pp_count", 32'(bus.Count), 32'd2);
        check32("pp_pc", bus.Pred_pc, 32'h408);
        step(1'b1, 32'h500, 1'b1, 1'b1);
        check32("stall_count", 32'(bus.Count), 32'd2);
        check32("stall_pc", bus.Pred_pc, 32'h408);
        pop_exp(1'b1, 32'h408, 2);
        pop_exp(1'b1, 32'h108, 1);

        // Resolve: correct, then wrong prediction, then idle
        resolve(32'h1008, 32'h1008, 1'b0);
        resolve(32'h1008, 32'h2008, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset while Mispredict is high and the stack is non-empty
        step(1'b1, 32'h700, 1'b0, 1'b0);
        step(1'b1, 32'h800, 1'b0, 1'b0);
        resolve(32'h1008, 32'h3008, 1'b1);
        check32("pre_reset_mispredict", {31'b0, bus.Mispredict}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check32("async_reset_count", 32'(bus.Count), 32'd0);
        check32("async_reset_mispredict", {31'b0, bus.Mispredict}, 32'd0);
        check32("async_reset_valid", {31'b0, bus.Pred_valid}, 32'd0);
        check32("async_reset_pc", bus.Pred_pc, 32'h0);
        @(negedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check32("post_reset_count", 32'(bus.Count), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        check32("pred_queue_drained", 32'(pred_q.size()), 32'd0);
        check32("mp_queue_drained", 32'(mp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
